// File: rtl/div_pkg.sv
// Shared types and constants for the sign-magnitude divider request front-end.
package div_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        HOLD    = 3'd4
    } div_ctl_state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;

endpackage

// File: rtl/div_req_ctrl.sv
// Divider request/response controller with busy-edge tracking and watchdog.
// Optional DIVCTL_ZERO_CHK_EN: zero-magnitude divisors are answered locally.
module div_req_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 48,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              div_start,
    output logic [DATA_W-1:0] div_x,
    output logic [DATA_W-1:0] div_y,
    input  logic              div_busy,
    input  logic [DATA_W-1:0] div_z,
    input  logic [DATA_W-1:0] div_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [DATA_W-1:0] out_r,
    output logic [1:0]        out_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    div_ctl_state_t   state_q;
    div_ctl_state_t   state_d;
    logic [CNT_W-1:0] wd_q;
    logic             rdy_q;
    logic             accept;
    logic             y_zero;
    logic             in_wait;
    logic             done;
    logic             tmo;

`ifdef DIVCTL_ZERO_CHK_EN
    assign y_zero = (in_y[DATA_W-2:0] == '0);
`else
    assign y_zero = 1'b0;
`endif

    assign accept  = (state_q == IDLE) && rdy_q && in_valid;
    assign in_wait = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign done    = (state_q == WAIT_LO) && !div_busy;
    assign tmo     = in_wait && (wd_q == TMO_LAST) && !done;

    assign in_ready  = rdy_q;
    assign div_start = (state_q == ISSUE);
    assign out_valid = (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = y_zero ? HOLD : ISSUE;
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (tmo)           state_d = HOLD;
                else if (div_busy) state_d = WAIT_LO;
            end
            WAIT_LO: if (done || tmo) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            wd_q    <= '0;
            div_x   <= '0;
            div_y   <= '0;
            out_z   <= '0;
            out_r   <= '0;
            out_err <= ERR_OK;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            if (state_q == ISSUE) wd_q <= '0;
            else if (in_wait)     wd_q <= wd_q + 1'b1;
            if (accept) begin
                div_x <= in_x;
                div_y <= in_y;
            end
            // Zero-divisor answer: saturated quotient, dividend as remainder
            if (accept && y_zero) begin
                out_z   <= {in_x[DATA_W-1] ^ in_y[DATA_W-1],
                            {(DATA_W-1){1'b1}}};
                out_r   <= in_x;
                out_err <= ERR_DIV0;
            end
            if (done) begin
                out_z   <= div_z;
                out_r   <= div_r;
                out_err <= ERR_OK;
            end
            if (tmo) begin
                out_z   <= '0;
                out_r   <= '0;
                out_err <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Scoreboard bench for div_req_ctrl with a behavioural divider core.
module tb_div_req_ctrl;

    localparam int LAT = 5;
    localparam int TMO = 48;

    typedef struct {
        logic [31:0] z;
        logic [31:0] r;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic        div_start;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_busy;
    logic [31:0] div_z;
    logic [31:0] div_r;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic [31:0] out_r;
    logic [1:0]  out_err;

    int   n_assert = 0;
    int   n_fail = 0;
    int   starts = 0;
    exp_t q[$];

    logic        stuck = 1'b0;
    logic        busy_q;
    int          cnt;
    logic [31:0] ez;
    logic [31:0] er;

    always #5 clk = ~clk;

    div_req_ctrl #(.DATA_W(32), .TIMEOUT_CYC(TMO), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_z(div_z), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_r(out_r), .out_err(out_err)
    );

    // Divider core model: busy for LAT cycles, results valid at busy fall
    assign div_busy = busy_q | stuck;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            cnt    <= 0;
            div_z  <= '0;
            div_r  <= '0;
        end else if (busy_q) begin
            if (cnt == 1) begin
                busy_q <= 1'b0;
                div_z  <= ez;
                div_r  <= er;
            end
            cnt <= cnt - 1;
        end else if (div_start) begin
            busy_q <= 1'b1;
            cnt    <= LAT;
            div_z  <= 32'hDEAD_BEEF;
            div_r  <= 32'hBAAD_F00D;
            if (div_y[30:0] == '0) begin
                ez <= {div_x[31] ^ div_y[31], 31'h7FFF_FFFF};
                er <= div_x;
            end else begin
                ez <= {div_x[31] ^ div_y[31], div_x[30:0] / div_y[30:0]};
                er <= {div_x[31], div_x[30:0] % div_y[30:0]};
            end
        end
    end

    always @(posedge clk) if (rstn && div_start) starts++;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_result: got z=%0h with empty queue", out_z);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_z", 64'(out_z), 64'(e.z));
                check("out_r", 64'(out_r), 64'(e.r));
                check("out_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("out_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z,
                          input logic [31:0] r, input logic [1:0] err,
                          input int lat_exp, input int nstart);
        int s0;
        int lat;
        exp_t e;
        e.z = z;
        e.r = r;
        e.err = err;
        q.push_back(e);
        s0 = starts;
        drive(x, y);
        wait_out(lat);
        check({name, "_lat"}, 64'(lat), 64'(lat_exp));
        @(posedge clk); #1;
        check({name, "_starts"}, 64'(starts), 64'(s0 + nstart));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   s0;
        int   lat;
        logic stable;
        exp_t e;

        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_div_xy", {div_x, div_y}, 64'd0);
        check("rst_out_zr", {out_z, out_r}, 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        run_op("t1", 32'h0000_0064, 32'h0000_0007,
               32'h0000_000E, 32'h0000_0002, 2'b00, LAT + 3, 1);
        run_op("t2", 32'h8000_0064, 32'h0000_0007,
               32'h8000_000E, 32'h8000_0002, 2'b00, LAT + 3, 1);
        run_op("v3", 32'h0000_0005, 32'h8000_0003,
               32'h8000_0001, 32'h0000_0002, 2'b00, LAT + 3, 1);
        run_op("v4", 32'hFFFF_FFFF, 32'h0000_0010,
               32'h87FF_FFFF, 32'h8000_000F, 2'b00, LAT + 3, 1);
        run_op("v5", 32'h0000_0003, 32'h0000_0009,
               32'h0000_0000, 32'h0000_0003, 2'b00, LAT + 3, 1);

        // T3: backpressure with a second request waiting
        out_ready = 1'b0;
        e.z = 32'h0000_000E; e.r = 32'h0000_0002; e.err = 2'b00;
        q.push_back(e);
        e.z = 32'h0000_000E; e.r = 32'h8000_0002; e.err = 2'b00;
        q.push_back(e);
        s0 = starts;
        drive(32'h0000_0064, 32'h0000_0007);
        wait_out(lat);
        in_x = 32'h8000_0064;
        in_y = 32'h8000_0007;
        in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_z !== 32'h0000_000E || out_r !== 32'h0000_0002 ||
                out_err !== 2'b00 || !out_valid || in_ready)
                stable = 1'b0;
        end
        check("t3_stable", 64'(stable), 64'd1);
        check("t3_no_accept", 64'(starts), 64'(s0 + 1));
        out_ready = 1'b1;
        drive(32'h8000_0064, 32'h8000_0007);
        wait_out(lat);
        check("t3_lat2", 64'(lat), 64'(LAT + 3));
        @(posedge clk); #1;
        check("t3_starts", 64'(starts), 64'(s0 + 2));

        // T4: zero-magnitude divisor
`ifdef DIVCTL_ZERO_CHK_EN
        run_op("t4", 32'h0000_0009, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h0000_0009, 2'b10, 1, 0);
`else
        run_op("t4", 32'h0000_0009, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h0000_0009, 2'b00, LAT + 3, 1);
`endif

        // T5: divider busy stuck high
        stuck = 1'b1;
        run_op("t5", 32'h0000_0064, 32'h0000_0007,
               32'h0000_0000, 32'h0000_0000, 2'b01, TMO + 2, 1);
        stuck = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        // T6: reset while waiting for busy to fall
        drive(32'h0000_0064, 32'h0000_0007);
        lat = 0;
        while (!div_busy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("t6_in_ready", 64'(in_ready), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_div_xy", {div_x, div_y}, 64'd0);
        check("t6_out", {out_z, out_r}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("t6_ready", 64'(in_ready), 64'd1);
        run_op("t6_next", 32'h0000_0064, 32'h0000_0007,
               32'h0000_000E, 32'h0000_0002, 2'b00, LAT + 3, 1);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
